// File: rtl/divider_sequencer_pkg.sv
// Shared definitions for the restoring divider: default operand width and
// the sequencer state encoding.
package divider_sequencer_pkg;

    localparam int bit_width = 8;

    typedef enum logic [1:0] {
        div_state_idle = 2'd0,
        div_state_run  = 2'd1,
        div_state_done = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_sequencer_subtractor.sv
// Unsigned subtractor with borrow-out, used for the divider's trial subtraction.
module subtractor #(
    parameter int width = 9
) (
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_b,
    output logic [width-1:0] o_diff,
    output logic             o_borrow
);

    logic [width:0] w_full;

    assign w_full   = {1'b0, i_a} - {1'b0, i_b};
    assign o_diff   = w_full[width-1:0];
    assign o_borrow = w_full[width];

endmodule

// File: rtl/divider_sequencer.sv
// Multi-cycle restoring unsigned divider: one quotient bit per clock through a
// single shared width+1 bit subtractor.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one trial subtraction per cycle, width cycles total
// DONE  | one-cycle done pulse; a new start is accepted here too
module divider_sequencer
    import divider_sequencer_pkg::*;
#(
    parameter int width = bit_width
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             divide_by_zero
);

    localparam int cnt_w = $clog2(width + 1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [width:0]   r_rem;
    logic [width-1:0] r_dvd_shift;
    logic [width-1:0] r_quo_shift;
    logic [width-1:0] r_dvsr;
    logic [cnt_w-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_borrow;
    logic [width:0]   w_rem_shift;
    logic [width:0]   w_diff;
    logic [width:0]   w_rem_next;
    logic [width-1:0] w_quo_next;
    logic             w_unused;

    assign w_accept    = start && (r_state != div_state_run);
    assign w_last      = (r_state == div_state_run) && (r_cnt == cnt_w'(1));
    assign w_rem_shift = {r_rem[width-1:0], r_dvd_shift[width-1]};
    assign w_rem_next  = w_borrow ? w_rem_shift : w_diff;
    assign w_quo_next  = {r_quo_shift[width-2:0], ~w_borrow};
    // R never exceeds the divisor, so its top bit only guards the subtraction
    assign w_unused    = ^{r_rem[width], r_quo_shift[width-1]};

    subtractor #(.width(width + 1)) u_subtractor (
        .i_a      (w_rem_shift),
        .i_b      ({1'b0, r_dvsr}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= div_state_idle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            div_state_idle: if (start) w_state_next = div_state_run;
            div_state_run: begin
                busy = 1'b1;
                if (r_cnt == cnt_w'(1)) w_state_next = div_state_done;
            end
            div_state_done: begin
                done         = 1'b1;
                w_state_next = start ? div_state_run : div_state_idle;
            end
            default: w_state_next = div_state_idle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rem          <= '0;
            r_dvd_shift    <= '0;
            r_quo_shift    <= '0;
            r_dvsr         <= '0;
            r_cnt          <= '0;
            quotient       <= '0;
            remainder      <= '0;
            divide_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_rem          <= '0;
            r_dvd_shift    <= dividend;
            r_quo_shift    <= '0;
            r_dvsr         <= divisor;
            r_cnt          <= cnt_w'(width);
            divide_by_zero <= (divisor == '0);
        end else if (r_state == div_state_run) begin
            r_rem       <= w_rem_next;
            r_dvd_shift <= {r_dvd_shift[width-2:0], 1'b0};
            r_quo_shift <= w_quo_next;
            r_cnt       <= r_cnt - cnt_w'(1);
            if (w_last) begin
                quotient  <= w_quo_next;
                remainder <= w_rem_next[width-1:0];
            end
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// Self-checking bench for divider_sequencer: vector table plus scoreboard,
// with hand-written sequences for ignored start, mid-run reset and back-to-back.
module tb_divider_sequencer;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       divide_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    divider_sequencer #(.width(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .dividend       (dividend),
        .divisor        (divisor),
        .busy           (busy),
        .done           (done),
        .quotient       (quotient),
        .remainder      (remainder),
        .divide_by_zero (divide_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // scoreboard consumer: every done pulse must match the oldest pushed result
    always @(negedge clock) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pulse");
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("divide_by_zero", divide_by_zero, mon_e.z);
                check("busy_in_done", busy, 0);
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                         input logic [7:0] r, input logic z, input bit push);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (push) sb.push_back('{q: q, r: r, z: z});
        @(posedge clock); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clock); #1;
            lat++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles want done", lat);
        end
    endtask

    vec_t vecs[9];
    int   lat;
    int   bc;

    initial begin
        vecs[0] = '{dvd: 8'd100, dvs: 8'd7,   q: 8'd14,  r: 8'd2,   z: 1'b0};
        vecs[1] = '{dvd: 8'd255, dvs: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
        vecs[2] = '{dvd: 8'd5,   dvs: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0};
        vecs[3] = '{dvd: 8'd77,  dvs: 8'd0,   q: 8'd255, r: 8'd77,  z: 1'b1};
        vecs[4] = '{dvd: 8'd10,  dvs: 8'd3,   q: 8'd3,   r: 8'd1,   z: 1'b0};
        vecs[5] = '{dvd: 8'd0,   dvs: 8'd5,   q: 8'd0,   r: 8'd0,   z: 1'b0};
        vecs[6] = '{dvd: 8'd255, dvs: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
        vecs[7] = '{dvd: 8'd254, dvs: 8'd255, q: 8'd0,   r: 8'd254, z: 1'b0};
        vecs[8] = '{dvd: 8'd128, dvs: 8'd16,  q: 8'd8,   r: 8'd0,   z: 1'b0};

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", divide_by_zero, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].z, 1'b1);
            wait_done(lat, bc);
            check("latency", lat, 9);
            check("busy_cycles", bc, 8);
            @(posedge clock); #1;
            for (int k = 0; k < 20; k++) begin
                check("hold_quotient", quotient, vecs[i].q);
                check("hold_remainder", remainder, vecs[i].r);
                check("hold_dbz", divide_by_zero, vecs[i].z);
                @(posedge clock); #1;
            end
        end

        // start pulsed in the fourth RUN cycle must be ignored
        issue(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check("busy_before_ignored_start", busy, 1);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("ignored_start_latency", lat, 5);
        repeat (12) @(posedge clock);
        #1;
        check("idle_after_ignored", busy, 0);

        // asynchronous reset in the middle of RUN discards the operation
        issue(8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", divide_by_zero, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        repeat (12) @(posedge clock);
        #1;
        check("no_done_after_reset", sb.size(), 0);
        check("idle_after_reset", busy, 0);
        issue(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b1);
        wait_done(lat, bc);
        check("post_reset_latency", lat, 9);
        @(posedge clock); #1;

        // back-to-back with start held high
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        sb.push_back('{q: 8'd14, r: 8'd2, z: 1'b0});
        @(posedge clock); #1;
        wait_done(lat, bc);
        check("b2b_first_latency", lat, 9);
        dividend = 8'd60;
        divisor  = 8'd8;
        sb.push_back('{q: 8'd7, r: 8'd4, z: 1'b0});
        @(posedge clock); #1;
        check("b2b_accepted_in_done", busy, 1);
        wait_done(lat, bc);
        check("b2b_done_spacing", lat, 9);
        start = 1'b0;
        @(posedge clock); #1;
        check("b2b_idle", busy, 0);
        check("b2b_hold_quotient", quotient, 7);
        check("b2b_hold_remainder", remainder, 4);

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
